exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter BIT_NUMBER, default 64: operand and result width.
REQ-002 Parameter ADDR_NUMBER, default 5: destination register address width.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: reset is synchronous and active-high.
REQ-005 Port in_valid, input, 1: an operation is presented on opcode/operand_a/operand_b/in_dest_addr.
REQ-006 Port in_ready, output, 1: the unit can accept an operation this cycle.
REQ-007 Port opcode, input, 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-008 Port operand_a, input, BIT_NUMBER: first operand (register-file data_out_1).
REQ-009 Port operand_b, input, BIT_NUMBER: second operand (register-file data_out_2).
REQ-010 Port in_dest_addr, input, ADDR_NUMBER: destination register of the operation.
REQ-011 Port write_enable, output, 1: writeback strobe to the register file.
REQ-012 Port dest_addr, output, ADDR_NUMBER: writeback register address.
REQ-013 Port write_data, output, BIT_NUMBER: writeback result.
REQ-014 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, MUL, and WB.
REQ-016 in_ready SHALL equal 1 only in IDLE; acceptance SHALL occur on the rising edge where in_valid and in_ready are both high.
REQ-017 On acceptance of a non-MUL opcode, the result, in_dest_addr, and opcode SHALL be registered, and the state SHALL go IDLE->WB.
REQ-018 ADD/SUB SHALL produce the result modulo 2^BIT_NUMBER; carry and borrow are discarded.
REQ-019 SHL/SHR SHALL be logical shifts by operand_b[log2(BIT_NUMBER)-1:0]; upper bits of operand_b are ignored, and a shift amount of 0 returns operand_a.
REQ-020 On acceptance of MUL, operands SHALL be latched and the state SHALL go IDLE->MUL.
REQ-021 MUL SHALL be an iterative shift-add over exactly BIT_NUMBER cycles, then go MUL->WB.
REQ-022 The MUL result SHALL be the lower BIT_NUMBER bits of the unsigned product.
REQ-023 In WB, write_enable SHALL be 1 for exactly one cycle, with dest_addr and write_data stable for the whole cycle; WB SHALL then go to IDLE.
REQ-024 Outputs SHALL be held stable for the whole WB cycle because the register file captures on the falling clock edge.
REQ-025 Outside WB, write_enable SHALL be 0; dest_addr and write_data SHALL hold their last written values.
REQ-026 Latency from the acceptance edge to write_enable high SHALL be 1 cycle for non-MUL ops and BIT_NUMBER+1 cycles for MUL.
REQ-027 Maximum throughput SHALL be one non-MUL op every 2 cycles.
REQ-028 Inputs presented while in_ready is 0 SHALL be ignored and SHALL NOT corrupt latched operands.
REQ-029 The operand order of the final add in MUL SHALL NOT depend on in_valid activity during MUL.

Reset
REQ-030 When reset is 1 at a rising edge, state SHALL become IDLE, and write_enable, dest_addr, write_data, and busy SHALL become 0.
REQ-031 When reset is 1 at a rising edge, the multiplier accumulator and counter SHALL clear.
REQ-032 Reset during MUL or WB SHALL abort the operation with no writeback, including when it coincides with a WB cycle.
REQ-033 Reset has priority over acceptance; in_valid asserted together with reset SHALL NOT be accepted.
REQ-034 In the cycle after reset deasserts, in_ready SHALL be 1.

Verification
REQ-035 ADD: a=0xFFFF_FFFF_FFFF_FFFF, b=1, dest=3 -> write_enable on the next cycle, dest_addr=3, write_data=0.
REQ-036 SUB and shifts: SUB a=0, b=1 -> 0xFFFF_FFFF_FFFF_FFFF; SHL a=1, b=0x43 -> 0x8; SHR a=0x8000_0000_0000_0000, b=63 -> 1.
REQ-037 MUL: a=0x1_0000_0001, b=0x1_0000_0001, dest=7 -> busy for 65 cycles, write_enable at cycle 65, write_data=0x2_0000_0001.
REQ-038 Back-to-back: in_valid held high with AND then OR -> second op accepted 2 cycles after the first, and exactly one write_enable pulse per op.
REQ-039 Reset mid-MUL: assert reset at cycle 20 of MUL -> no write_enable ever for that op, outputs 0, in_ready=1 one cycle after reset drops.
REQ-040 Ignored input: change operands during MUL -> result equals the product of the originally latched operands.

Source files
------------

// File: rtl/exec_unit.sv
// Single-issue execution unit: combinational ALU ops plus an iterative shift-add
// multiplier, with a one-cycle writeback strobe toward the register file.
module exec_unit #(
  parameter int BIT_NUMBER  = 64,
  parameter int ADDR_NUMBER = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             opcode,
  input  logic [BIT_NUMBER-1:0]  operand_a,
  input  logic [BIT_NUMBER-1:0]  operand_b,
  input  logic [ADDR_NUMBER-1:0] in_dest_addr,
  output logic                   write_enable,
  output logic [ADDR_NUMBER-1:0] dest_addr,
  output logic [BIT_NUMBER-1:0]  write_data,
  output logic                   busy
);

  localparam int SW = $clog2(BIT_NUMBER);
  localparam logic [SW-1:0] CNT_LAST = SW'(BIT_NUMBER - 1);

  typedef enum logic [1:0] {IDLE, MUL, WB} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110, OP_MUL = 3'b111
  } op_t;

  state_t                 state, state_next;
  op_t                    op_q;
  logic [BIT_NUMBER-1:0]  mcand, mplier, acc, acc_sum, alu_res;
  logic [SW-1:0]          cnt;
  logic [ADDR_NUMBER-1:0] dest_q;
  logic                   accept;

  assign accept   = in_valid && (state == IDLE);
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  // Reset coinciding with the WB cycle must suppress the falling-edge capture.
  assign write_enable = (state == WB) && !reset;

  assign acc_sum = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    alu_res = '0;
    case (op_t'(opcode))
      OP_ADD:  alu_res = operand_a + operand_b;
      OP_SUB:  alu_res = operand_a - operand_b;
      OP_AND:  alu_res = operand_a & operand_b;
      OP_OR:   alu_res = operand_a | operand_b;
      OP_XOR:  alu_res = operand_a ^ operand_b;
      OP_SHL:  alu_res = operand_a << operand_b[SW-1:0];
      OP_SHR:  alu_res = operand_a >> operand_b[SW-1:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (op_t'(opcode) == OP_MUL) ? MUL : WB;
      MUL:  if (cnt == CNT_LAST) state_next = WB;
      WB:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= OP_ADD;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      dest_q     <= '0;
      dest_addr  <= '0;
      write_data <= '0;
    end else begin
      if (accept) begin
        op_q <= op_t'(opcode);
        if (op_t'(opcode) == OP_MUL) begin
          mcand  <= operand_a;
          mplier <= operand_b;
          acc    <= '0;
          cnt    <= '0;
          dest_q <= in_dest_addr;
        end else begin
          write_data <= alu_res;
          dest_addr  <= in_dest_addr;
        end
      end
      if (state == MUL) begin
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        acc    <= acc_sum;
        cnt    <= cnt + 1'b1;
        // Outputs keep the previous writeback until the product is complete.
        if (cnt == CNT_LAST && op_q == OP_MUL) begin
          write_data <= acc_sum;
          dest_addr  <= dest_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: ALU ops, multiplier latency/result, back-to-back
// issue, and reset aborts.
module tb_exec_unit;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         XOR_ = 3'b100, SHL = 3'b101, SHR = 3'b110, MUL = 3'b111;

  logic        clk, reset, in_valid, in_ready, write_enable, busy;
  logic [2:0]  opcode;
  logic [63:0] operand_a, operand_b, write_data;
  logic [4:0]  in_dest_addr, dest_addr;

  int checks = 0;
  int errors = 0;

  exec_unit #(.BIT_NUMBER(64), .ADDR_NUMBER(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .in_dest_addr(in_dest_addr), .write_enable(write_enable),
    .dest_addr(dest_addr), .write_data(write_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] d);
    in_valid = 1'b1; opcode = op; operand_a = a; operand_b = b; in_dest_addr = d;
  endtask

  task automatic alu_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] d, input logic [63:0] exp);
    present(op, a, b, d);
    step();
    in_valid = 1'b0;
    check({tag, "_we"}, write_enable, 1);
    check({tag, "_data"}, write_data, exp);
    check({tag, "_dest"}, dest_addr, d);
    step();
    check({tag, "_we_drop"}, write_enable, 0);
    check({tag, "_hold"}, write_data, exp);
  endtask

  task automatic mul_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] d, input logic [63:0] exp,
                        input logic [63:0] prev_data, input bit noise);
    int cyc;
    present(MUL, a, b, d);
    step();
    cyc = 1;
    check({tag, "_busy1"}, busy, 1);
    check({tag, "_prevdata"}, write_data, prev_data);
    while (write_enable !== 1'b1 && cyc < 80) begin
      if (noise) present(MUL, {$urandom, $urandom}, {$urandom, $urandom}, 5'(cyc));
      else in_valid = 1'b0;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 65);
    check({tag, "_data"}, write_data, exp);
    check({tag, "_dest"}, dest_addr, d);
    step();
    check({tag, "_we_drop"}, write_enable, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; in_valid = 1'b0; opcode = '0;
    operand_a = '0; operand_b = '0; in_dest_addr = '0;
    step(); step();
    check("rst_we", write_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_data", write_data, 0);
    check("rst_dest", dest_addr, 0);
    reset = 1'b0;
    check("rst_ready", in_ready, 1);

    alu_op("add_wrap", ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd3, 64'd0);
    alu_op("sub_borrow", SUB, 64'd0, 64'd1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    alu_op("shl_mask", SHL, 64'd1, 64'h43, 5'd2, 64'h8);
    alu_op("shr_63", SHR, 64'h8000_0000_0000_0000, 64'd63, 5'd4, 64'd1);
    alu_op("shl_zero", SHL, 64'h1234, 64'h40, 5'd5, 64'h1234);
    alu_op("xor", XOR_, 64'hFF00_FF00, 64'h0FF0_0FF0, 5'd6, 64'hF0F0_F0F0);

    mul_op("mul_big", 64'h1_0000_0001, 64'h1_0000_0001, 5'd7, 64'h2_0000_0001,
           64'hF0F0_F0F0, 1'b0);
    mul_op("mul_noise", 64'd6, 64'd7, 5'd8, 64'd42, 64'h2_0000_0001, 1'b1);

    // Back-to-back AND then OR with in_valid held high.
    present(AND_, 64'hF0F0, 64'hFF00, 5'd4);
    step();
    check("b2b_and_we", write_enable, 1);
    check("b2b_and_data", write_data, 64'hF000);
    check("b2b_and_ready", in_ready, 0);
    present(OR_, 64'h0F, 64'hF0, 5'd5);
    step();
    check("b2b_gap_we", write_enable, 0);
    check("b2b_gap_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("b2b_or_we", write_enable, 1);
    check("b2b_or_data", write_data, 64'hFF);
    check("b2b_or_dest", dest_addr, 5'd5);
    step();
    check("b2b_end_we", write_enable, 0);

    // Reset at cycle 20 of a multiply, with a competing request held during reset.
    present(MUL, 64'd3, 64'd5, 5'd9);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 19; i++) step();
    check("midmul_busy", busy, 1);
    reset = 1'b1;
    present(ADD, 64'd1, 64'd1, 5'd10);
    step();
    check("midmul_rst_we", write_enable, 0);
    check("midmul_rst_busy", busy, 0);
    check("midmul_rst_data", write_data, 0);
    check("midmul_rst_dest", dest_addr, 0);
    reset = 1'b0;
    in_valid = 1'b0;
    check("midmul_ready", in_ready, 1);
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (write_enable === 1'b1 || busy === 1'b1) pulses++;
    end
    check("midmul_no_wb", 64'(pulses), 0);

    // Reset landing on the WB cycle must suppress the strobe.
    present(ADD, 64'd2, 64'd3, 5'd11);
    step();
    in_valid = 1'b0;
    check("wbrst_pre_we", write_enable, 1);
    reset = 1'b1;
    #1;
    check("wbrst_we_low", write_enable, 0);
    step();
    reset = 1'b0;
    check("wbrst_data", write_data, 0);
    check("wbrst_dest", dest_addr, 0);
    check("wbrst_ready", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
